// File: rtl/control_fsm_pkg.sv
// riscv_ctrl_pkg: shared encodings for the RV32I multicycle control unit.
//   - FSM state codes (4-bit, legacy-compatible localparams)
//   - RV32I opcode constants
//   - ALU operation, immediate-format and datapath mux select codes
// HALT only exists when CONTROL_ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

    localparam int SW = 4;

    localparam logic [SW-1:0] S_FETCH    = 4'd0;
    localparam logic [SW-1:0] S_DECODE   = 4'd1;
    localparam logic [SW-1:0] S_MEMADR   = 4'd2;
    localparam logic [SW-1:0] S_MEMREAD  = 4'd3;
    localparam logic [SW-1:0] S_MEMWB    = 4'd4;
    localparam logic [SW-1:0] S_MEMWRITE = 4'd5;
    localparam logic [SW-1:0] S_EXECR    = 4'd6;
    localparam logic [SW-1:0] S_EXECI    = 4'd7;
    localparam logic [SW-1:0] S_ALUWB    = 4'd8;
    localparam logic [SW-1:0] S_BRANCH   = 4'd9;
    localparam logic [SW-1:0] S_JAL      = 4'd10;
    localparam logic [SW-1:0] S_JALR1    = 4'd11;
    localparam logic [SW-1:0] S_JALR2    = 4'd12;
    localparam logic [SW-1:0] S_LUI      = 4'd13;
    localparam logic [SW-1:0] S_AUIPC    = 4'd14;
`ifdef CONTROL_ILLEGAL_TRAP_EN
    localparam logic [SW-1:0] S_HALT     = 4'd15;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] A_OLDPC = 2'd0;
    localparam logic [1:0] A_PC    = 2'd1;
    localparam logic [1:0] A_REG   = 2'd2;

    localparam logic [1:0] B_REG   = 2'd0;
    localparam logic [1:0] B_IMM   = 2'd1;
    localparam logic [1:0] B_FOUR  = 2'd2;

    localparam logic [2:0] OUT_ALUREG = 3'd0;
    localparam logic [2:0] OUT_ALUOUT = 3'd1;
    localparam logic [2:0] OUT_DATA   = 3'd2;

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: control unit <-> datapath bundle.
//   master : control unit (reads decoded fields/flags, drives controls)
//   slave  : datapath side (drives fields/flags, reads controls)
interface control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero_flag;
    logic       alu_lt;

    logic       adr_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       output_en;
    logic [2:0] out_mux_sel;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a_sel;
    logic [1:0] alu_src_b_sel;
    logic [3:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7, zero_flag, alu_lt,
        output adr_src, pc_write, ir_write, mem_write, reg_write, output_en,
               out_mux_sel, imm_sel, alu_src_a_sel, alu_src_b_sel, alu_ctrl,
               instr_done, illegal
    );

    modport slave (
        output opcode, funct3, funct7, zero_flag, alu_lt,
        input  adr_src, pc_write, ir_write, mem_write, reg_write, output_en,
               out_mux_sel, imm_sel, alu_src_a_sel, alu_src_b_sel, alu_ctrl,
               instr_done, illegal
    );
endinterface

// File: rtl/control_alu_decoder.sv
// control_alu_decoder: funct3 / funct7[5] -> alu_ctrl for OP and OP-IMM.
//   funct3    in  3  instr[14:12]
//   funct7_b5 in  1  instr[30]
//   is_rtype  in  1  R-type; only then does funct7[5] select SUB
//   alu_ctrl  out 4  ALU operation code
module control_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_rtype,
    output logic [3:0] alu_ctrl
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (funct3)
            // ADDI has imm[10] in bit 30, so it must never turn into SUB
            3'd0: alu_ctrl = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'd1: alu_ctrl = ALU_SLL;
            3'd2: alu_ctrl = ALU_SLT;
            3'd3: alu_ctrl = ALU_SLTU;
            3'd4: alu_ctrl = ALU_XOR;
            3'd5: alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'd6: alu_ctrl = ALU_OR;
            3'd7: alu_ctrl = ALU_AND;
            default: alu_ctrl = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle Moore control unit for the RV32I datapath.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-low reset (state -> FETCH, strobes held 0)
//   bus  control_fsm_if.master: opcode/funct3/funct7/flags in,
//        mux selects, write strobes, alu_ctrl, instr_done, illegal out
// Build option CONTROL_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in
// HALT with illegal set; otherwise they retire as a NOP.
module control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master bus
);
    logic [STATE_W-1:0] state, state_nxt;
    logic [3:0] alu_dec;
    logic       taken;
    logic       pc_w, ir_w, mem_w, reg_w, out_en, done;

    control_alu_decoder u_alu_dec (
        .funct3   (bus.funct3),
        .funct7_b5(bus.funct7[5]),
        .is_rtype (bus.opcode == OP_R),
        .alu_ctrl (alu_dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nxt;
    end

    always_comb begin
        case (bus.funct3)
            3'd0:       taken = bus.zero_flag;
            3'd1:       taken = !bus.zero_flag;
            3'd4, 3'd6: taken = bus.alu_lt;
            3'd5, 3'd7: taken = !bus.alu_lt;
            default:    taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_R:              state_nxt = S_EXECR;
                    OP_I:              state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR1;
                    OP_LUI:            state_nxt = S_LUI;
                    OP_AUIPC:          state_nxt = S_AUIPC;
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    default:           state_nxt = S_HALT;
`else
                    default:           state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_nxt = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_nxt = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL, S_JALR2, S_LUI, S_AUIPC: state_nxt = S_ALUWB;
            S_JALR1:  state_nxt = S_JALR2;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            S_HALT:   state_nxt = S_HALT;
`endif
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        bus.adr_src       = 1'b0;
        bus.out_mux_sel   = OUT_ALUREG;
        bus.imm_sel       = IMM_I;
        bus.alu_src_a_sel = A_OLDPC;
        bus.alu_src_b_sel = B_REG;
        bus.alu_ctrl      = ALU_ADD;
        pc_w   = 1'b0;
        ir_w   = 1'b0;
        mem_w  = 1'b0;
        reg_w  = 1'b0;
        out_en = 1'b0;
        done   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_w = 1'b1;
                pc_w = 1'b1;
                bus.alu_src_a_sel = A_PC;
                bus.alu_src_b_sel = B_FOUR;
                bus.out_mux_sel   = OUT_ALUOUT;
            end
            S_DECODE: begin
                // Branch/JAL target lands in the ALU reg for the next state
                bus.alu_src_b_sel = B_IMM;
                bus.imm_sel = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
                case (bus.opcode)
                    OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: done = 1'b0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    default: done = 1'b0;
`else
                    default: done = 1'b1;   // unknown opcode retires as NOP
`endif
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a_sel = A_REG;
                bus.alu_src_b_sel = B_IMM;
                bus.imm_sel = (bus.opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEMREAD: bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.out_mux_sel = OUT_DATA;
                reg_w  = 1'b1;
                out_en = 1'b1;
                done   = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_w = 1'b1;
                done  = 1'b1;
            end
            S_EXECR: begin
                bus.alu_src_a_sel = A_REG;
                bus.alu_ctrl      = alu_dec;
            end
            S_EXECI: begin
                bus.alu_src_a_sel = A_REG;
                bus.alu_src_b_sel = B_IMM;
                bus.alu_ctrl      = alu_dec;
            end
            S_ALUWB: begin
                reg_w  = 1'b1;
                out_en = 1'b1;
                done   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a_sel = A_REG;
                bus.alu_ctrl = !bus.funct3[2] ? ALU_SUB :
                               (bus.funct3[1] ? ALU_SLTU : ALU_SLT);
                pc_w = taken;
                done = 1'b1;
            end
            // PC takes the target from the ALU reg while the ALU forms PC+4
            S_JAL, S_JALR2: begin
                pc_w = 1'b1;
                bus.alu_src_b_sel = B_FOUR;
            end
            S_JALR1: begin
                bus.alu_src_a_sel = A_REG;
                bus.alu_src_b_sel = B_IMM;
            end
            S_LUI: begin
                bus.alu_src_b_sel = B_IMM;
                bus.imm_sel  = IMM_U;
                bus.alu_ctrl = ALU_PASS_B;
            end
            S_AUIPC: begin
                bus.alu_src_b_sel = B_IMM;
                bus.imm_sel = IMM_U;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so nothing writes while rst is low
    assign bus.pc_write   = rst & pc_w;
    assign bus.ir_write   = rst & ir_w;
    assign bus.mem_write  = rst & mem_w;
    assign bus.reg_write  = rst & reg_w;
    assign bus.output_en  = rst & out_en;
    assign bus.instr_done = rst & done;

`ifdef CONTROL_ILLEGAL_TRAP_EN
    assign bus.illegal = (state == S_HALT);
`else
    assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed-vector bench for control_fsm.
// Each cyc() call checks one FSM cycle's outputs against hand-computed
// values, then advances to the next cycle (sampled 1 ns after negedge).
// Strobe vector order: {adr_src,pc_write,ir_write,mem_write,reg_write,
//                       output_en,instr_done}.
module tb_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    control_fsm_if bus ();

    control_fsm dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S_F    = 7'b0110000;
    localparam logic [6:0] S_WB   = 7'b0000111;
    localparam logic [6:0] S_NONE = 7'b0000000;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic lt);
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7    = f7;
        bus.zero_flag = z;
        bus.alu_lt    = lt;
    endtask

    task automatic cyc(input string tag, input logic [6:0] s, input int om,
                       input int a, input int b, input int alu, input int imm);
        chk({tag, ".strb"}, 32'({bus.adr_src, bus.pc_write, bus.ir_write, bus.mem_write,
                                 bus.reg_write, bus.output_en, bus.instr_done}), 32'(s));
        chk({tag, ".omux"}, 32'(bus.out_mux_sel), om);
        chk({tag, ".a"},    32'(bus.alu_src_a_sel), a);
        chk({tag, ".b"},    32'(bus.alu_src_b_sel), b);
        chk({tag, ".alu"},  32'(bus.alu_ctrl), alu);
        chk({tag, ".imm"},  32'(bus.imm_sel), imm);
        @(negedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input int imm);
        cyc({tag, ".F"}, S_F, 1, 1, 2, 0, 0);
        cyc({tag, ".D"}, S_NONE, 0, 0, 1, 0, imm);
    endtask

    initial begin
        set_instr(7'h00, 3'd0, 7'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        // In reset: FETCH selects visible, strobes forced low
        cyc("rst_hold", S_NONE, 1, 1, 2, 0, 0);
        rst = 1'b1;
        #1;

        // ADD x3,x1,x2 (0x002081B3)
        set_instr(7'b0110011, 3'd0, 7'h00, 1'b0, 1'b0);
        chk("add.illegal", 32'(bus.illegal), 0);
        fetch_decode("add", 2);
        cyc("add.X", S_NONE, 0, 2, 0, 0, 0);
        cyc("add.WB", S_WB, 0, 0, 0, 0, 0);

        // SUB
        set_instr(7'b0110011, 3'd0, 7'h20, 1'b0, 1'b0);
        fetch_decode("sub", 2);
        cyc("sub.X", S_NONE, 0, 2, 0, 1, 0);
        cyc("sub.WB", S_WB, 0, 0, 0, 0, 0);

        // SRAI
        set_instr(7'b0010011, 3'd5, 7'h20, 1'b0, 1'b0);
        fetch_decode("srai", 2);
        cyc("srai.X", S_NONE, 0, 2, 1, 7, 0);
        cyc("srai.WB", S_WB, 0, 0, 0, 0, 0);

        // ADDI with imm[10] set: must stay ADD
        set_instr(7'b0010011, 3'd0, 7'h20, 1'b0, 1'b0);
        fetch_decode("addi", 2);
        cyc("addi.X", S_NONE, 0, 2, 1, 0, 0);
        cyc("addi.WB", S_WB, 0, 0, 0, 0, 0);

        // BEQ taken (zero=1)
        set_instr(7'b1100011, 3'd0, 7'h00, 1'b1, 1'b0);
        fetch_decode("beq", 2);
        cyc("beq.BR", 7'b0100001, 0, 2, 0, 1, 0);

        // BNE with zero=1: not taken
        set_instr(7'b1100011, 3'd1, 7'h00, 1'b1, 1'b0);
        fetch_decode("bne", 2);
        cyc("bne.BR", 7'b0000001, 0, 2, 0, 1, 0);

        // BGEU, alu_lt=0: taken, SLTU
        set_instr(7'b1100011, 3'd7, 7'h00, 1'b0, 1'b0);
        fetch_decode("bgeu", 2);
        cyc("bgeu.BR", 7'b0100001, 0, 2, 0, 9, 0);

        // LW: five cycles
        set_instr(7'b0000011, 3'd2, 7'h00, 1'b0, 1'b0);
        fetch_decode("lw", 2);
        cyc("lw.MA", S_NONE, 0, 2, 1, 0, 0);
        cyc("lw.MR", 7'b1000000, 0, 0, 0, 0, 0);
        cyc("lw.WB", S_WB, 2, 0, 0, 0, 0);

        // SW: FETCH, DECODE, MEMADR, MEMWRITE
        set_instr(7'b0100011, 3'd2, 7'h00, 1'b0, 1'b0);
        fetch_decode("sw", 2);
        cyc("sw.MA", S_NONE, 0, 2, 1, 0, 1);
        cyc("sw.MW", 7'b1001001, 0, 0, 0, 0, 0);

        // JAL: J-immediate in DECODE, PC load + link in JAL state
        set_instr(7'b1101111, 3'd0, 7'h00, 1'b0, 1'b0);
        fetch_decode("jal", 3);
        cyc("jal.J", 7'b0100000, 0, 0, 2, 0, 0);
        cyc("jal.WB", S_WB, 0, 0, 0, 0, 0);

        // LUI
        set_instr(7'b0110111, 3'd0, 7'h00, 1'b0, 1'b0);
        fetch_decode("lui", 2);
        cyc("lui.L", S_NONE, 0, 0, 1, 10, 4);
        cyc("lui.WB", S_WB, 0, 0, 0, 0, 0);

        // Reset asserted in the middle of MEMREAD
        set_instr(7'b0000011, 3'd2, 7'h00, 1'b0, 1'b0);
        fetch_decode("lwr", 2);
        cyc("lwr.MA", S_NONE, 0, 2, 1, 0, 0);
        rst = 1'b0;
        #1;
        cyc("rst_mid", S_NONE, 1, 1, 2, 0, 0);
        cyc("rst_mid2", S_NONE, 1, 1, 2, 0, 0);
        rst = 1'b1;
        #1;
        fetch_decode("lwr2", 2);
        cyc("lwr2.MA", S_NONE, 0, 2, 1, 0, 0);
        cyc("lwr2.MR", 7'b1000000, 0, 0, 0, 0, 0);
        cyc("lwr2.WB", S_WB, 2, 0, 0, 0, 0);

        // Unknown opcode 0x7F
        set_instr(7'h7F, 3'd0, 7'h00, 1'b0, 1'b0);
        cyc("ill.F", S_F, 1, 1, 2, 0, 0);
`ifdef CONTROL_ILLEGAL_TRAP_EN
        chk("ill.D.illegal", 32'(bus.illegal), 0);
        cyc("ill.D", S_NONE, 0, 0, 1, 0, 2);
        for (int i = 0; i < 20; i++) begin
            chk("halt.illegal", 32'(bus.illegal), 1);
            chk("halt.strb", 32'({bus.pc_write, bus.ir_write, bus.mem_write,
                                  bus.reg_write, bus.output_en, bus.instr_done}), 0);
            @(negedge clk);
            #1;
        end
`else
        cyc("ill.D", 7'b0000001, 0, 0, 1, 0, 2);
        chk("ill.illegal", 32'(bus.illegal), 0);
        cyc("ill.F2", S_F, 1, 1, 2, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
